// File: rtl/warp_lsu_pkg.sv
// Shared types for the warp load/store unit: warp phases, data word and LSU states.
package warp_lsu_pkg;

   localparam int DATA_WIDTH    = 16;
   localparam int ADDRESS_WIDTH = DATA_WIDTH;

   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic [2:0] {
      WARP_IDLE    = 3'd0,
      WARP_FETCH   = 3'd1,
      WARP_DECODE  = 3'd2,
      WARP_REQUEST = 3'd3,
      WARP_WAIT    = 3'd4,
      WARP_EXECUTE = 3'd5,
      WARP_UPDATE  = 3'd6,
      WARP_DONE    = 3'd7
   } warp_state_t;

   typedef enum logic [1:0] {
      LSU_IDLE       = 2'd0,
      LSU_REQUESTING = 2'd1,
      LSU_DONE       = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/warp_lsu_lane_picker.sv
// Lowest-set-bit finder over a lane mask; any_o flags a non-empty mask.
module lane_picker #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]         mask_i,
   output logic [$clog2(WIDTH)-1:0] idx_o,
   output logic                     any_o
);
   localparam int IDX_W = $clog2(WIDTH);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = IDX_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/warp_lsu.sv
// Warp load/store unit: serializes one memory transaction per active lane over one port.
//   state          | meaning
//   LSU_IDLE       | waiting for a load/store in WARP_REQUEST
//   LSU_REQUESTING | valid high for lane idx_q until its handshake
//   LSU_DONE       | all lanes served; wait for WARP_UPDATE
module warp_lsu
   import warp_lsu_pkg::*;
#(
   parameter int THREADS_PER_WARP = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [THREADS_PER_WARP-1:0] thread_enable,
   input  warp_state_t                 warp_state,
   input  logic                        decoded_mem_read_enable,
   input  logic                        decoded_mem_write_enable,
   input  data_t                       rs1 [THREADS_PER_WARP],
   input  data_t                       rs2 [THREADS_PER_WARP],
   output logic                        mem_read_valid,
   output logic [ADDRESS_WIDTH-1:0]    mem_read_address,
   input  logic                        mem_read_ready,
   input  data_t                       mem_read_data,
   output logic                        mem_write_valid,
   output logic [ADDRESS_WIDTH-1:0]    mem_write_address,
   output data_t                       mem_write_data,
   input  logic                        mem_write_ready,
   output lsu_state_t                  lsu_state,
   output data_t                       lsu_out [THREADS_PER_WARP]
);
   localparam int IDX_W = $clog2(THREADS_PER_WARP);

   lsu_state_t                  state_q, state_d;
   logic [THREADS_PER_WARP-1:0] mask_q, mask_d, clr_mask;
   logic [IDX_W-1:0]            idx_q, idx_d, start_idx, next_idx;
   logic                        is_read_q, is_read_d;
   logic                        start_any, next_any, start, hs;
   data_t                       lsu_out_q [THREADS_PER_WARP];

   assign start = enable && (warp_state == WARP_REQUEST)
                  && (decoded_mem_read_enable || decoded_mem_write_enable);
   assign hs    = (state_q == LSU_REQUESTING)
                  && (is_read_q ? mem_read_ready : mem_write_ready);

   always_comb begin
      clr_mask        = mask_q;
      clr_mask[idx_q] = 1'b0;
   end

   lane_picker #(.WIDTH(THREADS_PER_WARP)) u_start_pick (
      .mask_i (thread_enable),
      .idx_o  (start_idx),
      .any_o  (start_any)
   );

   lane_picker #(.WIDTH(THREADS_PER_WARP)) u_next_pick (
      .mask_i (clr_mask),
      .idx_o  (next_idx),
      .any_o  (next_any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LSU_IDLE;
         mask_q    <= '0;
         idx_q     <= '0;
         is_read_q <= 1'b0;
         for (int i = 0; i < THREADS_PER_WARP; i++) lsu_out_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         idx_q     <= idx_d;
         is_read_q <= is_read_d;
         if (hs && is_read_q) lsu_out_q[idx_q] <= mem_read_data;
      end
   end

   // Read wins when both op bits are set.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      idx_d     = idx_q;
      is_read_d = is_read_q;
      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               mask_d    = thread_enable;
               idx_d     = start_idx;
               is_read_d = decoded_mem_read_enable;
               state_d   = start_any ? LSU_REQUESTING : LSU_DONE;
            end
         end
         LSU_REQUESTING: begin
            if (hs) begin
               mask_d = clr_mask;
               idx_d  = next_idx;
               if (!next_any) state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            if (warp_state == WARP_UPDATE) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // Address and data are forced to zero whenever no request is outstanding.
   always_comb begin
      mem_read_valid    = 1'b0;
      mem_read_address  = '0;
      mem_write_valid   = 1'b0;
      mem_write_address = '0;
      mem_write_data    = '0;
      if (state_q == LSU_REQUESTING) begin
         if (is_read_q) begin
            mem_read_valid   = 1'b1;
            mem_read_address = rs1[idx_q];
         end else begin
            mem_write_valid   = 1'b1;
            mem_write_address = rs1[idx_q];
            mem_write_data    = rs2[idx_q];
         end
      end
   end

   assign lsu_state = state_q;
   assign lsu_out   = lsu_out_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Directed bench for warp_lsu with a latency-programmable memory responder and a transaction scoreboard.
module tb_warp_lsu;
   import warp_lsu_pkg::*;

   localparam int T = 4;

   typedef struct packed {
      logic  is_wr;
      data_t addr;
      data_t data;
   } txn_t;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [T-1:0] thread_enable;
   warp_state_t  warp_state;
   logic         decoded_mem_read_enable;
   logic         decoded_mem_write_enable;
   data_t        rs1 [T];
   data_t        rs2 [T];
   logic         mem_read_valid;
   data_t        mem_read_address;
   logic         mem_read_ready;
   data_t        mem_read_data;
   logic         mem_write_valid;
   data_t        mem_write_address;
   data_t        mem_write_data;
   logic         mem_write_ready;
   lsu_state_t   lsu_state;
   data_t        lsu_out [T];

   int   compared   = 0;
   int   mismatched = 0;
   int   mem_lat    = 0;
   logic force_ready = 1'b0;
   int   valid_cnt  = 0;
   int   both_cnt   = 0;
   txn_t exp_q [$];
   txn_t obs_q [$];
   data_t exp_out [T];

   warp_lsu #(.THREADS_PER_WARP(T)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .thread_enable            (thread_enable),
      .warp_state               (warp_state),
      .decoded_mem_read_enable  (decoded_mem_read_enable),
      .decoded_mem_write_enable (decoded_mem_write_enable),
      .rs1                      (rs1),
      .rs2                      (rs2),
      .mem_read_valid           (mem_read_valid),
      .mem_read_address         (mem_read_address),
      .mem_read_ready           (mem_read_ready),
      .mem_read_data            (mem_read_data),
      .mem_write_valid          (mem_write_valid),
      .mem_write_address        (mem_write_address),
      .mem_write_data           (mem_write_data),
      .mem_write_ready          (mem_write_ready),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic txn_t mk(input logic w, input data_t a, input data_t d);
      txn_t t;
      t.is_wr = w;
      t.addr  = a;
      t.data  = d;
      return t;
   endfunction

   // Memory: ready pulses mem_lat cycles after valid; loads return address+1.
   initial begin
      int cnt;
      cnt = 0;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = '0;
      forever begin
         @(negedge clk);
         mem_read_ready  = 1'b0;
         mem_write_ready = 1'b0;
         if (mem_read_valid && mem_write_valid) both_cnt++;
         if (mem_read_valid || mem_write_valid) begin
            valid_cnt++;
            if (cnt == mem_lat) begin
               cnt = 0;
               if (mem_read_valid) begin
                  mem_read_ready = 1'b1;
                  mem_read_data  = mem_read_address + 16'd1;
                  obs_q.push_back(mk(1'b0, mem_read_address, '0));
               end else begin
                  mem_write_ready = 1'b1;
                  obs_q.push_back(mk(1'b1, mem_write_address, mem_write_data));
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            if (force_ready) begin
               mem_read_ready  = 1'b1;
               mem_write_ready = 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drain_sb(input string tag);
      txn_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            check({tag, "_missing_txn_addr"}, 64'hDEAD, {48'd0, e.addr});
         end else begin
            o = obs_q.pop_front();
            check({tag, "_txn_kind"}, {63'd0, o.is_wr}, {63'd0, e.is_wr});
            check({tag, "_txn_addr"}, {48'd0, o.addr}, {48'd0, e.addr});
            check({tag, "_txn_data"}, {48'd0, o.data}, {48'd0, e.data});
         end
      end
      check({tag, "_extra_txns"}, 64'(obs_q.size()), 64'd0);
      obs_q.delete();
   endtask

   task automatic push_exp(input logic is_wr, input logic [T-1:0] mask);
      for (int i = 0; i < T; i++) begin
         if (mask[i]) begin
            exp_q.push_back(mk(is_wr, rs1[i], is_wr ? rs2[i] : '0));
            if (!is_wr) exp_out[i] = rs1[i] + 16'd1;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [T-1:0] mask, input logic [T-1:0] mask_after,
                         input int lat, input int exp_done);
      int n;
      @(negedge clk);
      mem_lat                  = lat;
      enable                   = 1'b1;
      thread_enable            = mask;
      warp_state               = WARP_REQUEST;
      decoded_mem_read_enable  = rd;
      decoded_mem_write_enable = wr;
      push_exp(!rd, mask);
      @(posedge clk);
      #1;
      warp_state               = WARP_WAIT;
      enable                   = 1'b0;
      thread_enable            = mask_after;
      decoded_mem_read_enable  = 1'b0;
      decoded_mem_write_enable = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (lsu_state != LSU_DONE && n < 200);
      check({tag, "_done_cycle"}, 64'(n), 64'(exp_done));
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      warp_state = WARP_UPDATE;
      @(posedge clk);
      #1;
      check({tag, "_back_to_idle"}, 64'(lsu_state), 64'(LSU_IDLE));
      warp_state = WARP_IDLE;
   endtask

   task automatic check_lsu_out(input string tag);
      for (int i = 0; i < T; i++)
         check($sformatf("%s_lsu_out%0d", tag, i), {48'd0, lsu_out[i]}, {48'd0, exp_out[i]});
   endtask

   initial begin
      int v0;
      reset                    = 1'b1;
      enable                   = 1'b0;
      thread_enable            = '0;
      warp_state               = WARP_IDLE;
      decoded_mem_read_enable  = 1'b0;
      decoded_mem_write_enable = 1'b0;
      for (int i = 0; i < T; i++) begin
         rs1[i]     = data_t'(16'h10 + 4 * i);
         rs2[i]     = data_t'(3 * i);
         exp_out[i] = '0;
      end

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_state", 64'(lsu_state), 64'(LSU_IDLE));
      check("rst_rvalid", {63'd0, mem_read_valid}, 64'd0);
      check("rst_wvalid", {63'd0, mem_write_valid}, 64'd0);
      check("rst_raddr", {48'd0, mem_read_address}, 64'd0);
      check("rst_waddr", {48'd0, mem_write_address}, 64'd0);
      check("rst_wdata", {48'd0, mem_write_data}, 64'd0);
      check_lsu_out("rst");
      repeat (20) @(negedge clk);
      check("idle_no_valid", 64'(valid_cnt), 64'd0);

      // Sparse load, zero latency
      run_op("ld1010", 1'b1, 1'b0, 4'b1010, 4'b1010, 0, 3);
      drain_sb("ld1010");
      check_lsu_out("ld1010");
      finish_op("ld1010");

      // Full-mask store, latency 2
      for (int i = 0; i < T; i++) rs1[i] = data_t'(16'h40 + 4 * i);
      run_op("st1111", 1'b0, 1'b1, 4'b1111, 4'b1111, 2, 13);
      drain_sb("st1111");
      check_lsu_out("st1111");
      finish_op("st1111");

      // Empty mask
      v0 = valid_cnt;
      run_op("ld0000", 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 1);
      check("ld0000_no_valid", 64'(valid_cnt - v0), 64'd0);
      drain_sb("ld0000");
      finish_op("ld0000");

      // Reset during the second of three loads
      for (int i = 0; i < T; i++) rs1[i] = data_t'(16'h10 + 4 * i);
      @(negedge clk);
      mem_lat                 = 2;
      enable                  = 1'b1;
      thread_enable           = 4'b0111;
      warp_state              = WARP_REQUEST;
      decoded_mem_read_enable = 1'b1;
      push_exp(1'b0, 4'b0111);
      @(posedge clk);
      #1;
      warp_state              = WARP_WAIT;
      enable                  = 1'b0;
      decoded_mem_read_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_lane0_loaded", {48'd0, lsu_out[0]}, 64'h11);
      check("rst_mid_still_req", 64'(lsu_state), 64'(LSU_REQUESTING));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_mid_state", 64'(lsu_state), 64'(LSU_IDLE));
      check("rst_mid_rvalid", {63'd0, mem_read_valid}, 64'd0);
      check("rst_mid_raddr", {48'd0, mem_read_address}, 64'd0);
      for (int i = 0; i < T; i++) exp_out[i] = '0;
      check_lsu_out("rst_mid");
      check("rst_mid_obs_count", 64'(obs_q.size()), 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      drain_sb("rst_mid");
      v0 = valid_cnt;
      force_ready = 1'b1;
      @(posedge clk);
      #1;
      force_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("late_ready_state", 64'(lsu_state), 64'(LSU_IDLE));
      check("late_ready_no_valid", 64'(valid_cnt - v0), 64'd0);
      check_lsu_out("late_ready");

      // Both op bits, mask changed and enable dropped mid-operation
      v0 = valid_cnt;
      run_op("rdwr", 1'b1, 1'b1, 4'b0101, 4'b1010, 1, 5);
      drain_sb("rdwr");
      check("rdwr_valid_cycles", 64'(valid_cnt - v0), 64'd4);
      check_lsu_out("rdwr");
      finish_op("rdwr");

      check("never_both_valids", 64'(both_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/warp_lsu.md
# warp_lsu

Warp-level load/store unit that sits directly downstream of the per-warp register file. It consumes the file's `rs1` (address) and `rs2` (store data) vectors, serializes one memory transaction per active thread over a single data-memory port, and returns per-thread load results on `lsu_out` for write-back during `WARP_UPDATE`. The scheduler holds the warp in `WARP_WAIT` until `lsu_state == LSU_DONE`.

## Interface
Parameters:
- `THREADS_PER_WARP`, 32: lanes per warp; power of two, ≥2.
- `DATA_WIDTH`, `` `DATA_WIDTH ``: data and address width.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  warp enable; gates start only.
- `thread_enable`  in  THREADS_PER_WARP  execution mask.
- `warp_state`  in  warp_state_t  current warp phase.
- `decoded_mem_read_enable`  in  1  load instruction.
- `decoded_mem_write_enable`  in  1  store instruction.
- `rs1`  in  data_t[THREADS_PER_WARP]  per-thread address.
- `rs2`  in  data_t[THREADS_PER_WARP]  per-thread store data.
- `mem_read_valid`  out  1  read request.
- `mem_read_address`  out  DATA_WIDTH  read address.
- `mem_read_ready`  in  1  read accepted; data valid this cycle.
- `mem_read_data`  in  DATA_WIDTH  read data.
- `mem_write_valid`  out  1  write request.
- `mem_write_address`  out  DATA_WIDTH  write address.
- `mem_write_data`  out  DATA_WIDTH  write data.
- `mem_write_ready`  in  1  write accepted.
- `lsu_state`  out  lsu_state_t  `LSU_IDLE` / `LSU_REQUESTING` / `LSU_DONE`.
- `lsu_out`  out  data_t[THREADS_PER_WARP]  per-thread load result.

## Operation
State `LSU_IDLE`:
- Start condition: `enable && warp_state == WARP_REQUEST && (read || write)`.
- On start, latch:
  - `thread_enable` into `active_mask`;
  - op into `is_read`. Read wins if both read and write are set.
- Next state is `LSU_REQUESTING` if `active_mask != 0`, else `LSU_DONE`.
- `idx` is loaded with the lowest set bit of `active_mask`.

State `LSU_REQUESTING`:
- Drive `mem_*_valid = 1` with address `rs1[idx]`; for writes, data `rs2[idx]`.
- `rs1`/`rs2` are registered by the register file on the start edge, so they are stable from the cycle after start onward.
- Handshake completes on the first edge where valid and ready are both high:
  - read: `lsu_out[idx] <= mem_read_data`;
  - clear `active_mask[idx]`;
  - `idx` moves to the next-lowest set bit.
  - If no bits remain, next state is `LSU_DONE` and valid drops.
  - Otherwise the state stays `LSU_REQUESTING` and valid stays high with the new address (back-to-back requests).
- `mem_*_ready` must pulse for exactly one cycle per accepted request. Ready seen while valid is low is ignored.
- `enable` deasserting mid-operation does not abort; the transaction sequence completes.

State `LSU_DONE`:
- Valid outputs are 0.
- Transition to `LSU_IDLE` on `warp_state == WARP_UPDATE`.

General rules:
- Only the valid matching the op (`mem_read_valid` for loads, `mem_write_valid` for stores) is ever asserted.
- Store instructions never modify `lsu_out`.
- `lsu_out` for masked-off lanes holds its previous value.
- Mask or `rs1`/`rs2` changes of non-current lanes during an operation have no effect.

## Timing
- Reset values: state `LSU_IDLE`, both valids 0, addresses and write data 0, all `lsu_out` 0, `active_mask` 0, `idx` 0.
- Reset mid-operation: all of the above on the next edge. An in-flight request is abandoned.
- Start edge E0 → valid high in cycle E0+1.
- With memory ready latency L ≥ 0 cycles after valid, each lane costs L+1 cycles.
- k active lanes: `LSU_DONE` is visible k·(L+1)+1 cycles after E0.
- Zero active lanes: `LSU_DONE` at E0+1, with no memory traffic.
- A load result is visible on `lsu_out[idx]` in the cycle after its handshake. All results are stable once `LSU_DONE` is reached.

## Structure
- `common.sv` additions:
  - `lsu_state_t` enum (2 bits: `LSU_IDLE`=0, `LSU_REQUESTING`=1, `LSU_DONE`=2).
  - `ADDRESS_WIDTH` constant.
- `warp_state_t`, `data_t`, and `DATA_WIDTH` are reused from `common.sv`.
- Sub-module `lane_picker`: combinational lowest-set-bit finder returning `$clog2(THREADS_PER_WARP)` index plus `any` flag. It is used for both the start and advance selections.

## Test plan
- Reset, then idle: all outputs zero; state `LSU_IDLE`; no valid over 20 cycles.
- Load, mask `4'b1010` (T=4), `rs1` = {0x10, 0x14, 0x18, 0x1C}, L=0, memory returns address+1:
  - reads 0x14 then 0x1C on consecutive cycles;
  - `lsu_out[1]`=0x15, `lsu_out[3]`=0x1D, lanes 0/2 unchanged;
  - `LSU_DONE` at E0+3.
- Store, full mask, `rs2[i]` = i·3, L=2: four writes in lane order with correct address/data; `LSU_DONE` at E0+13; `lsu_out` untouched.
- Empty mask with load: `LSU_DONE` at E0+1; no valid; back to `LSU_IDLE` on `WARP_UPDATE`.
- Reset asserted during the second of three requests: valid 0, state `LSU_IDLE`, `lsu_out` 0 on next edge. A late ready afterwards is ignored.
- Read and write both set; `thread_enable` toggled mid-operation: only reads are issued, to the lanes latched at start.
